// File: rtl/modbus_pkg.sv
// Shared Modbus CRC16 definitions used by both the CRC generator and the CRC checker.
package modbus_pkg;

  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam int unsigned MODBUS_MIN_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;

  // One step of the reflected CRC16 shift register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc);
    return (crc >> 1) ^ (crc[0] ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/modbus_crc_checker_if.sv
// Byte stream in and per-frame result out for the Modbus CRC checker.
interface modbus_crc_checker_if;

  logic [7:0]  data;
  logic        valid;
  logic        last;
  logic        abort;
  logic        ready;
  logic        done;
  logic        crc_ok;
  logic        is_short;
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;
  logic [8:0]  len;

  modport master (
    output data, valid, last, abort,
    input  ready, done, crc_ok, is_short, crc_calc, crc_rx, len
  );

  modport slave (
    input  data, valid, last, abort,
    output ready, done, crc_ok, is_short, crc_calc, crc_rx, len
  );

endinterface

// File: rtl/crc16_byte_fold.sv
// Combinational fold of one byte into a Modbus CRC16 (eight unrolled shift steps).
module crc16_byte_fold
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = {crc_in[15:8], crc_in[7:0] ^ data_in};
    for (int i = 0; i < 8; i++) begin
      acc = crc16_step(acc);
    end
  end

  assign crc_out = acc;

endmodule

// File: rtl/modbus_crc_checker.sv
// Receive-side Modbus RTU CRC16 checker; one pass/fail result per frame.
// MODBUS_CRC_CHK_FAST_EN: fold each byte in a single cycle instead of an 8-cycle serial shift.
//
// state    | meaning
// ST_IDLE  | accepting bytes (o_ready high when enabled)
// ST_SHIFT | serial fold in progress, 8 shift steps
// ST_DONE  | result cycle, o_done registered on exit
module modbus_crc_checker
  import modbus_pkg::*;
#(
  parameter int unsigned MIN_LEN = MODBUS_MIN_LEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  modbus_crc_checker_if.slave  bus
);

  localparam logic [8:0] MIN_LEN_W  = 9'(MIN_LEN);
  localparam logic [8:0] LAST_MIN_W = 9'(MIN_LEN - 1);
`ifdef MODBUS_CRC_CHK_FAST_EN
  localparam bit FAST_MODE = 1'b1;
`else
  localparam bit FAST_MODE = 1'b0;
`endif

  crc_state_e  state_q, state_d;
  logic [15:0] crc_q;
  logic [7:0]  hold0_q, hold1_q;
  logic [8:0]  cnt_q;
  logic [15:0] rx_pend_q;
  logic        done_q, ok_q, short_q;
  logic [15:0] crc_rx_q;
  logic [8:0]  len_q;

  logic        accept, abort_en, fold, frame_short;
  logic [8:0]  cnt_inc;
  logic [15:0] fold_crc;

  assign abort_en    = i_enable && bus.abort;
  assign accept      = i_enable && (state_q == ST_IDLE) && bus.valid && !bus.abort;
  // The two newest bytes stay in the pipe, so the CRC bytes never reach the fold.
  assign fold        = accept && (cnt_q >= 9'd2) && (!bus.last || (cnt_q >= LAST_MIN_W));
  assign cnt_inc     = (cnt_q == 9'd511) ? cnt_q : cnt_q + 9'd1;
  assign frame_short = (cnt_q < MIN_LEN_W);

`ifdef MODBUS_CRC_CHK_FAST_EN
  crc16_byte_fold u_fold (
    .crc_in  (crc_q),
    .data_in (hold1_q),
    .crc_out (fold_crc)
  );
`else
  logic [2:0] step_q;
  logic       last_q;

  assign fold_crc = {crc_q[15:8], crc_q[7:0] ^ hold1_q};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_q <= 3'd0;
      last_q <= 1'b0;
    end else if (i_enable && !bus.abort) begin
      if (fold) begin
        step_q <= 3'd7;
        last_q <= bus.last;
      end else if (state_q == ST_SHIFT) begin
        step_q <= step_q - 3'd1;
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_en) begin
      state_d = ST_IDLE;
    end else if (i_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.last)                state_d = (fold && !FAST_MODE) ? ST_SHIFT : ST_DONE;
            else if (fold && !FAST_MODE) state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
`ifdef MODBUS_CRC_CHK_FAST_EN
          state_d = ST_IDLE;
`else
          if (step_q == 3'd0) state_d = last_q ? ST_DONE : ST_IDLE;
`endif
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_q     <= CRC16_INIT;
      hold0_q   <= 8'h00;
      hold1_q   <= 8'h00;
      cnt_q     <= 9'd0;
      rx_pend_q <= 16'h0000;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      short_q   <= 1'b0;
      crc_rx_q  <= 16'h0000;
      len_q     <= 9'd0;
    end else begin
      // The pulse is one cycle wide even if the enable drops right after it.
      done_q <= 1'b0;
      if (abort_en) begin
        crc_q   <= CRC16_INIT;
        cnt_q   <= 9'd0;
        hold0_q <= 8'h00;
        hold1_q <= 8'h00;
      end else if (i_enable) begin
        case (state_q)
          ST_IDLE: begin
            // An empty frame re-seeds the CRC, leaving the last result visible during o_done.
            if (fold)               crc_q <= fold_crc;
            else if (cnt_q == 9'd0) crc_q <= CRC16_INIT;
            if (accept) begin
              hold1_q <= hold0_q;
              hold0_q <= bus.data;
              cnt_q   <= cnt_inc;
              if (bus.last) rx_pend_q <= {bus.data, hold0_q};
            end
          end
          ST_SHIFT: crc_q <= crc16_step(crc_q);
          ST_DONE: begin
            done_q   <= 1'b1;
            ok_q     <= !frame_short && (crc_q == rx_pend_q);
            short_q  <= frame_short;
            crc_rx_q <= rx_pend_q;
            len_q    <= cnt_q;
            cnt_q    <= 9'd0;
            hold0_q  <= 8'h00;
            hold1_q  <= 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ready    = i_enable && (state_q == ST_IDLE);
  assign bus.done     = done_q;
  assign bus.crc_ok   = ok_q;
  assign bus.is_short = short_q;
  assign bus.crc_calc = crc_q;
  assign bus.crc_rx   = crc_rx_q;
  assign bus.len      = len_q;

endmodule
